// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_port_arbiter: round-robin share of one scoreboard write-back lane    |
// | with a single registered output stage.  Rev 1.0                         |
// +------------------------------------------------------------------------+
module wb_port_arbiter #(
    parameter int NR_REQ     = 4,
    parameter int TRANS_ID_W = 3,
    parameter int DATA_W     = 64,
    localparam int SRC_W     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic [NR_REQ-1:0]                    req_valid_i,
    output logic [NR_REQ-1:0]                    req_ready_o,
    input  logic [NR_REQ-1:0][TRANS_ID_W-1:0]    req_trans_id_i,
    input  logic [NR_REQ-1:0][DATA_W-1:0]        req_data_i,
    input  logic [NR_REQ-1:0]                    req_ex_valid_i,
    output logic                                 wb_valid_o,
    input  logic                                 wb_ready_i,
    output logic [TRANS_ID_W-1:0]                wb_trans_id_o,
    output logic [DATA_W-1:0]                    wb_data_o,
    output logic                                 wb_ex_valid_o,
    output logic [SRC_W-1:0]                     wb_src_o,
    output logic                                 idle_o
);

    localparam logic [SRC_W-1:0] c_last_idx = SRC_W'(NR_REQ - 1);

    logic                  r_wb_valid;
    logic [TRANS_ID_W-1:0] r_trans_id;
    logic [DATA_W-1:0]     r_data;
    logic                  r_ex_valid;
    logic [SRC_W-1:0]      r_src;
    logic [SRC_W-1:0]      r_rr_ptr;

    logic                  w_load_en;
    logic                  w_grant_vld;
    logic [SRC_W-1:0]      w_grant;
    logic                  w_hi_found;
    logic [SRC_W-1:0]      w_hi_idx;
    logic                  w_lo_found;
    logic [SRC_W-1:0]      w_lo_idx;

    // Ready is also masked by reset so nothing is accepted while the core is held in reset.
    assign w_load_en = rst_ni && !flush_i && (!r_wb_valid || wb_ready_i);

    // Lowest valid index at or above the pointer wins; otherwise lowest valid index overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = NR_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = SRC_W'(i);
                if (SRC_W'(i) >= r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SRC_W'(i);
                end
            end
        end
        w_grant_vld = w_lo_found;
        w_grant     = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    for (genvar i = 0; i < NR_REQ; i++) begin : g_ready
        assign req_ready_o[i] = w_load_en && w_grant_vld && (w_grant == SRC_W'(i));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wb_valid <= 1'b0;
            r_trans_id <= '0;
            r_data     <= '0;
            r_ex_valid <= 1'b0;
            r_src      <= '0;
            r_rr_ptr   <= '0;
        end else if (flush_i) begin
            r_wb_valid <= 1'b0;
        end else if (w_load_en) begin
            r_wb_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_trans_id <= req_trans_id_i[w_grant];
                r_data     <= req_data_i[w_grant];
                r_ex_valid <= req_ex_valid_i[w_grant];
                r_src      <= w_grant;
                r_rr_ptr   <= (w_grant == c_last_idx) ? '0 : w_grant + SRC_W'(1);
            end
        end
    end

    assign wb_valid_o    = r_wb_valid;
    assign wb_trans_id_o = r_trans_id;
    assign wb_data_o     = r_data;
    assign wb_ex_valid_o = r_ex_valid;
    assign wb_src_o      = r_src;
    assign idle_o        = !r_wb_valid && !(|req_valid_i);

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_ready_o));

    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wb_valid_o && !wb_ready_i) |=>
            $stable({wb_trans_id_o, wb_data_o, wb_ex_valid_o, wb_src_o}));

    a_flush_clears: assert property (@(posedge clk_i) disable iff (!rst_ni)
        flush_i |=> !wb_valid_o);

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter    |
// | (4-requester and 3-requester instances). Rev 1.0                        |
// +------------------------------------------------------------------------+
module tb_wb_port_arbiter;

    logic clk;
    logic rst_n;

    // 4-requester instance
    logic             flush;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][2:0]  req_tid;
    logic [3:0][63:0] req_data;
    logic [3:0]       req_ex;
    logic             wb_valid;
    logic             wb_ready;
    logic [2:0]       wb_tid;
    logic [63:0]      wb_data;
    logic             wb_ex;
    logic [1:0]       wb_src;
    logic             idle;

    // 3-requester instance
    logic             flush3;
    logic [2:0]       req_valid3;
    logic [2:0]       req_ready3;
    logic [2:0][2:0]  req_tid3;
    logic [2:0][63:0] req_data3;
    logic [2:0]       req_ex3;
    logic             wb_valid3;
    logic             wb_ready3;
    logic [2:0]       wb_tid3;
    logic [63:0]      wb_data3;
    logic             wb_ex3;
    logic [1:0]       wb_src3;
    logic             idle3;

    int err_cnt = 0;
    int chk_cnt = 0;

    wb_port_arbiter #(.NR_REQ(4), .TRANS_ID_W(3), .DATA_W(64)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_trans_id_i(req_tid), .req_data_i(req_data), .req_ex_valid_i(req_ex),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
        .wb_trans_id_o(wb_tid), .wb_data_o(wb_data), .wb_ex_valid_o(wb_ex),
        .wb_src_o(wb_src), .idle_o(idle)
    );

    wb_port_arbiter #(.NR_REQ(3), .TRANS_ID_W(3), .DATA_W(64)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush3),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3),
        .req_trans_id_i(req_tid3), .req_data_i(req_data3), .req_ex_valid_i(req_ex3),
        .wb_valid_o(wb_valid3), .wb_ready_i(wb_ready3),
        .wb_trans_id_o(wb_tid3), .wb_data_o(wb_data3), .wb_ex_valid_o(wb_ex3),
        .wb_src_o(wb_src3), .idle_o(idle3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int seq [6] = '{3, 0, 1, 2, 3, 0};

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = '0;
        wb_ready   = 1'b0;
        req_ex     = '0;
        flush3     = 1'b0;
        req_valid3 = '0;
        wb_ready3  = 1'b0;
        req_ex3    = '0;
        for (int i = 0; i < 4; i++) begin
            req_tid[i]  = 3'(i + 1);
            req_data[i] = 64'h100 + 64'(i);
        end
        for (int i = 0; i < 3; i++) begin
            req_tid3[i]  = 3'(i);
            req_data3[i] = 64'h30 + 64'(i);
        end

        // Reset state
        tick();
        tick();
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_wb_src", 64'(wb_src), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from index 2
        req_tid[2]  = 3'd5;
        req_data[2] = 64'hDEAD;
        req_ex[2]   = 1'b1;
        req_valid   = 4'b0100;
        wb_ready    = 1'b1;
        #1;
        chk("t1_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        req_ex[2] = 1'b0;
        chk("t1_wb_valid", 64'(wb_valid), 64'd1);
        chk("t1_wb_tid", 64'(wb_tid), 64'd5);
        chk("t1_wb_data", wb_data, 64'hDEAD);
        chk("t1_wb_ex", 64'(wb_ex), 64'd1);
        chk("t1_wb_src", 64'(wb_src), 64'd2);
        req_tid[2]  = 3'd3;
        req_data[2] = 64'h102;
        tick();
        chk("drain_wb_valid", 64'(wb_valid), 64'd0);
        chk("drain_idle", 64'(idle), 64'd1);

        // All valid: pointer was left at 3, so rotation is 3,0,1,2,3,0
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(1 << seq[k]));
            tick();
            chk($sformatf("rr_valid_%0d", k), 64'(wb_valid), 64'd1);
            chk($sformatf("rr_src_%0d", k), 64'(wb_src), 64'(seq[k]));
            chk($sformatf("rr_data_%0d", k), wb_data, 64'h100 + 64'(seq[k]));
        end

        // Hold src 0 result while req 1 waits
        wb_ready  = 1'b0;
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold_ready_%0d", k), 64'(req_ready), 64'd0);
            tick();
            chk($sformatf("hold_data_%0d", k), wb_data, 64'h100);
            chk($sformatf("hold_src_%0d", k), 64'(wb_src), 64'd0);
            chk($sformatf("hold_valid_%0d", k), 64'(wb_valid), 64'd1);
        end
        wb_ready = 1'b1;
        #1;
        chk("release_ready", 64'(req_ready), 64'h2);
        tick();
        chk("release_src", 64'(wb_src), 64'd1);
        chk("release_data", wb_data, 64'h101);
        chk("release_tid", 64'(wb_tid), 64'd2);

        // Flush overrides ready and pending grant; pointer stays at 2
        wb_ready  = 1'b0;
        req_valid = 4'b1000;
        #1;
        chk("pre_flush_ready", 64'(req_ready), 64'd0);
        tick();
        chk("pre_flush_src", 64'(wb_src), 64'd1);
        flush    = 1'b1;
        wb_ready = 1'b1;
        #1;
        chk("flush_ready", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0;
        chk("flush_wb_valid", 64'(wb_valid), 64'd0);
        req_valid = 4'b1111;
        #1;
        chk("post_flush_ready", 64'(req_ready), 64'h4);
        tick();
        chk("post_flush_src", 64'(wb_src), 64'd2);
        chk("post_flush_valid", 64'(wb_valid), 64'd1);

        // Asynchronous reset mid-cycle
        wb_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(wb_valid), 64'd0);
        chk("async_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        #1;
        chk("after_rst_ready", 64'(req_ready), 64'h1);
        tick();
        chk("after_rst_src", 64'(wb_src), 64'd0);
        req_valid = '0;

        // 3-requester wrap
        wb_ready3  = 1'b1;
        req_valid3 = 3'b010;
        #1;
        chk("n3_ready_a", 64'(req_ready3), 64'h2);
        tick();
        chk("n3_src_a", 64'(wb_src3), 64'd1);
        req_valid3 = 3'b011;
        #1;
        chk("n3_wrap_ready", 64'(req_ready3), 64'h1);
        tick();
        chk("n3_wrap_src", 64'(wb_src3), 64'd0);
        chk("n3_wrap_data", wb_data3, 64'h30);
        req_valid3 = 3'b111;
        #1;
        chk("n3_ptr1_ready", 64'(req_ready3), 64'h2);
        tick();
        #1;
        chk("n3_ptr2_ready", 64'(req_ready3), 64'h4);
        tick();
        chk("n3_last_src", 64'(wb_src3), 64'd2);
        #1;
        chk("n3_ptr0_ready", 64'(req_ready3), 64'h1);
        tick();
        chk("n3_ptr0_src", 64'(wb_src3), 64'd0);
        req_valid3 = '0;
        tick();
        chk("n3_idle", 64'(idle3), 64'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
